// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: drives a W-bit up/down count lo -> hi -> lo for a
// programmed number of passes, with hold, abort and completion/error pulses.
module updown_sweep_ctrl #(
    parameter int W  = 4,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [RW-1:0] reps,
    input  logic          hold,
    input  logic          abort,
    output logic [W-1:0]  count,
    output logic          dir,
    output logic [RW-1:0] pass,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [RW-1:0] pass_q, pass_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [RW-1:0] reps_q, reps_d;
    logic          err_q, err_d;
    logic [RW-1:0] pass_inc;

    assign pass_inc = pass_q + RW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        reps_d  = reps_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort in IDLE swallows a simultaneous start, including its err pulse
                if (start && !abort) begin
                    if ((lo < hi) && (reps != '0)) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        reps_d  = reps;
                        count_d = lo;
                        pass_d  = '0;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (count_q != hi_q) begin
                        count_d = count_q + W'(1);
                    end else begin
                        count_d = count_q - W'(1);
                        state_d = DOWN;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (count_q != lo_q) begin
                        count_d = count_q - W'(1);
                    end else begin
                        // later passes restart at lo+1 so lo is shown once per turnaround
                        pass_d = pass_inc;
                        if (pass_inc == reps_q) begin
                            state_d = DONE;
                        end else begin
                            count_d = lo_q + W'(1);
                            state_d = UP;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pass_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            reps_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            reps_q  <= reps_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign pass  = pass_q;
    assign dir   = (state_q != DOWN);
    assign busy  = (state_q == UP) || (state_q == DOWN);
    assign done  = (state_q == DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a fixed vector table, directed corner sequences and
// random stimulus, all checked against a trajectory-list model of the sweep.
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int RW = 4;

    logic          clk, rst, start, hold, abort;
    logic [W-1:0]  lo, hi;
    logic [RW-1:0] reps;
    logic [W-1:0]  count;
    logic          dir, busy, done, err;
    logic [RW-1:0] pass;

    updown_sweep_ctrl #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .reps(reps),
        .hold(hold), .abort(abort), .count(count), .dir(dir), .pass(pass),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  count;
        logic [RW-1:0] pass;
        logic          dir;
        logic          busy;
        logic          done;
        logic          err;
    } obs_t;

    typedef struct {
        logic          start;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        logic [RW-1:0] reps;
        logic          hold;
        logic          abort;
        obs_t          exp;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   edges  = 0;
    obs_t m;
    obs_t traj[$];
    int   mode;      // 0 idle, 1 sweeping, 2 completion cycle
    vec_t tbl[18];

    function automatic obs_t mk_obs(input int c, input int p, input logic d,
                                    input logic b, input logic dn, input logic e);
        obs_t o;
        o.count = W'(c);
        o.pass  = RW'(p);
        o.dir   = d;
        o.busy  = b;
        o.done  = dn;
        o.err   = e;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic st, input int l, input int h, input int r,
                                    input logic hd, input logic ab, input obs_t e);
        vec_t v;
        v.start = st;
        v.lo    = W'(l);
        v.hi    = W'(h);
        v.reps  = RW'(r);
        v.hold  = hd;
        v.abort = ab;
        v.exp   = e;
        return v;
    endfunction

    // Every value the sweep will show, one entry per unstalled edge, ending with the done cycle
    function automatic void build_traj(input int l, input int h, input int r);
        traj.delete();
        for (int p = 0; p < r; p++) begin
            for (int c = (p == 0) ? l : l + 1; c <= h; c++)
                traj.push_back(mk_obs(c, p, 1'b1, 1'b1, 1'b0, 1'b0));
            for (int c = h - 1; c >= l; c--)
                traj.push_back(mk_obs(c, p, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        traj.push_back(mk_obs(l, r, 1'b1, 1'b0, 1'b1, 1'b0));
    endfunction

    function automatic void model_reset();
        traj.delete();
        mode = 0;
        m = mk_obs(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void model_step();
        m.err = 1'b0;
        if (mode == 1) begin
            if (abort) begin
                traj.delete();
                mode   = 0;
                m.dir  = 1'b1;
                m.busy = 1'b0;
            end else if (!hold) begin
                m = traj.pop_front();
                if (m.done) mode = 2;
            end
        end else if (mode == 2) begin
            mode   = 0;
            m.done = 1'b0;
        end else if (start && !abort) begin
            if ((int'(lo) < int'(hi)) && (int'(reps) != 0)) begin
                build_traj(int'(lo), int'(hi), int'(reps));
                m    = traj.pop_front();
                mode = 1;
            end else begin
                m.err = 1'b1;
            end
        end
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a.count = count;
        a.pass  = pass;
        a.dir   = dir;
        a.busy  = busy;
        a.done  = done;
        a.err   = err;
        return a;
    endfunction

    task automatic check_output(input string name, input obs_t exp);
        obs_t a;
        a = actual();
        n_vec++;
        if (a !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got count=%0d pass=%0d dir=%0b busy=%0b done=%0b err=%0b, expected count=%0d pass=%0d dir=%0b busy=%0b done=%0b err=%0b",
                     name, a.count, a.pass, a.dir, a.busy, a.done, a.err,
                     exp.count, exp.pass, exp.dir, exp.busy, exp.done, exp.err);
        end
    endtask

    task automatic expect_true(input string name, input logic cond, input int got, input int want);
        n_vec++;
        if (cond !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cycle(input string name);
        @(posedge clk);
        model_step();
        edges++;
        @(negedge clk);
        check_output(name, m);
    endtask

    task automatic apply_stimulus(input logic st, input int l, input int h, input int r,
                                  input logic hd, input logic ab);
        start = st;
        lo    = W'(l);
        hi    = W'(h);
        reps  = RW'(r);
        hold  = hd;
        abort = ab;
    endtask

    task automatic launch(input string name, input int l, input int h, input int r);
        apply_stimulus(1'b1, l, h, r, 1'b0, 1'b0);
        cycle(name);
        edges = 0;
        start = 1'b0;
    endtask

    int k;

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        model_reset();

        tbl[0]  = mk_vec(1, 2, 4, 1, 0, 0, mk_obs(2, 0, 1, 1, 0, 0));
        tbl[1]  = mk_vec(0, 2, 4, 1, 0, 0, mk_obs(3, 0, 1, 1, 0, 0));
        tbl[2]  = mk_vec(0, 2, 4, 1, 0, 0, mk_obs(4, 0, 1, 1, 0, 0));
        tbl[3]  = mk_vec(0, 2, 4, 1, 0, 0, mk_obs(3, 0, 0, 1, 0, 0));
        tbl[4]  = mk_vec(0, 2, 4, 1, 0, 0, mk_obs(2, 0, 0, 1, 0, 0));
        tbl[5]  = mk_vec(0, 2, 4, 1, 0, 0, mk_obs(2, 1, 1, 0, 1, 0));
        tbl[6]  = mk_vec(1, 0, 9, 1, 0, 0, mk_obs(2, 1, 1, 0, 0, 0));
        tbl[7]  = mk_vec(1, 5, 5, 2, 0, 0, mk_obs(2, 1, 1, 0, 0, 1));
        tbl[8]  = mk_vec(0, 5, 5, 2, 0, 0, mk_obs(2, 1, 1, 0, 0, 0));
        tbl[9]  = mk_vec(1, 1, 6, 0, 0, 0, mk_obs(2, 1, 1, 0, 0, 1));
        tbl[10] = mk_vec(0, 1, 6, 0, 0, 0, mk_obs(2, 1, 1, 0, 0, 0));
        tbl[11] = mk_vec(1, 1, 3, 1, 0, 1, mk_obs(2, 1, 1, 0, 0, 0));
        tbl[12] = mk_vec(1, 3, 6, 1, 1, 0, mk_obs(3, 0, 1, 1, 0, 0));
        tbl[13] = mk_vec(0, 3, 6, 1, 1, 0, mk_obs(3, 0, 1, 1, 0, 0));
        tbl[14] = mk_vec(0, 3, 6, 1, 0, 0, mk_obs(4, 0, 1, 1, 0, 0));
        tbl[15] = mk_vec(1, 0, 1, 1, 0, 0, mk_obs(5, 0, 1, 1, 0, 0));
        tbl[16] = mk_vec(0, 3, 6, 1, 1, 1, mk_obs(5, 0, 1, 0, 0, 0));
        tbl[17] = mk_vec(0, 3, 6, 1, 0, 0, mk_obs(5, 0, 1, 0, 0, 0));

        @(negedge clk);
        check_output("reset_state", mk_obs(0, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // Basic sweep, done in IDLE, rejects, abort-suppressed start, hold ignored in IDLE
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(tbl[i].start, int'(tbl[i].lo), int'(tbl[i].hi), int'(tbl[i].reps),
                           tbl[i].hold, tbl[i].abort);
            cycle($sformatf("table_model_%0d", i));
            check_output($sformatf("table_%0d", i), tbl[i].exp);
        end
        apply_stimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Full range, three passes
        launch("full_start", 0, 15, 3);
        for (k = 0; k < 200 && done !== 1'b1; k++) cycle("full_range");
        expect_true("full_done_edge", edges == 91, edges, 91);
        expect_true("full_pass", pass == 4'd3, int'(pass), 3);
        cycle("full_idle");

        // Hold three cycles at count 5 delays done by three
        launch("hold_start", 1, 8, 1);
        for (k = 0; k < 20 && count != 4'd5; k++) cycle("hold_run");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("hold_freeze");
            expect_true("hold_count", count == 4'd5, int'(count), 5);
        end
        hold = 1'b0;
        for (k = 0; k < 40 && done !== 1'b1; k++) cycle("hold_resume");
        expect_true("hold_done_edge", edges == 18, edges, 18);
        cycle("hold_idle");

        // Start while busy ignored, then abort with hold at count 6
        launch("abort_start", 2, 9, 2);
        for (k = 0; k < 20 && count != 4'd4; k++) cycle("abort_run");
        apply_stimulus(1'b1, 0, 1, 1, 1'b0, 1'b0);
        cycle("busy_start");
        expect_true("busy_start_ignored", busy === 1'b1 && err === 1'b0 && count == 4'd5,
                    int'(count), 5);
        start = 1'b0;
        cycle("abort_pre");
        hold  = 1'b1;
        abort = 1'b1;
        cycle("abort_edge");
        check_output("abort_result", mk_obs(6, 0, 1, 0, 0, 0));
        hold  = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle("abort_idle");
            expect_true("abort_no_done", done === 1'b0, int'(done), 0);
        end

        // Asynchronous reset in DOWN at count 3
        launch("rst_start", 0, 5, 1);
        for (k = 0; k < 20 && !(dir === 1'b0 && count == 4'd3); k++) cycle("rst_run");
        rst = 1'b1;
        #1;
        model_reset();
        check_output("async_reset", mk_obs(0, 0, 1, 0, 0, 0));
        #2 rst = 1'b0;
        launch("post_rst_start", 2, 4, 1);
        for (k = 0; k < 20 && done !== 1'b1; k++) cycle("post_rst_run");
        expect_true("post_rst_done_edge", edges == 5, edges, 5);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                           $urandom_range(0, 39) == 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
